// File: rtl/rr_pkg.sv
// Shared round-robin helpers: wrapped index increment and index-width utilities.
// Latency: n/a (functions and types only).
// Backpressure: n/a.
//
// Contents:
//   RR_IDX_MAX_W : widest lane index supported by the helpers (N <= 256)
//   rr_idx_t     : lane index carrier, wide enough for any supported N
//   rr_idx_w(n)  : lane index width for n lanes (at least 1 bit)
//   rr_next(p,n) : (p + 1) mod n, wrapped with a single conditional subtract
package rr_pkg;

  localparam int unsigned RR_IDX_MAX_W = 8;

  typedef logic [RR_IDX_MAX_W-1:0] rr_idx_t;

  function automatic int unsigned rr_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // The increment is done one bit wider than the index so that p+1 == n is
  // representable; a single subtract of n then wraps it. This stays correct
  // when n is not a power of two, where a plain IW-bit rollover would not.
  function automatic rr_idx_t rr_next(input rr_idx_t ptr, input int unsigned n);
    logic [RR_IDX_MAX_W:0] sum;
    sum = {1'b0, ptr} + 1'b1;
    if (sum >= (RR_IDX_MAX_W+1)'(n)) begin
      sum = sum - (RR_IDX_MAX_W+1)'(n);
    end
    return sum[RR_IDX_MAX_W-1:0];
  endfunction

endpackage : rr_pkg

// File: rtl/rr_pick.sv
// Rotating-priority pick: first set bit of avail scanning upward from start.
// Latency: purely combinational.
// Backpressure: none; found=0 when no lane is available.
//
// Ports:
//   avail [N]  : per-lane availability
//   start [IW] : first lane index examined (must be < N)
//   found      : at least one lane available
//   sel   [IW] : chosen lane index (0 when found=0)
module rr_pick
  import rr_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = rr_idx_w(N)
) (
  input  logic [N-1:0]  avail,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] sel
);

  rr_idx_t idx;

  // Walk the N candidates in rotated order; the first hit wins and later
  // hits are masked by found.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = rr_idx_t'(start);
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && avail[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
      idx = rr_next(idx, N);
    end
  end

endmodule : rr_pick

// File: rtl/rr_dispatcher.sv
// One-to-N round-robin dispatcher: each accepted word goes to exactly one lane buffer.
// Latency: one cycle from accept to out_valid/out_data of the chosen lane.
// Backpressure: in_ready drops only when every lane buffer is full and not draining.
//
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_ready never looks at in_valid
//   in_data   [W]       : input word
//   out_valid [N]       : lane i buffer holds a word
//   out_ready [N]       : lane i consumer takes the word this cycle
//   out_data  [N*W]     : lane i word at bits [i*W +: W]
//   last_lane [IW]      : lane that received the most recent accepted word
module rr_dispatcher
  import rr_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  localparam int unsigned IW = rr_idx_w(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic [N*W-1:0] out_data,
  output logic [IW-1:0]  last_lane
);

  logic [N-1:0]        valid_q, valid_d;
  logic [N-1:0][W-1:0] data_q,  data_d;
  logic [IW-1:0]       last_q,  last_d;

  logic [N-1:0]  avail;
  rr_idx_t       start_full;
  logic [IW-1:0] start;
  logic          found;
  logic [IW-1:0] sel;
  logic          accept;

  // A lane can take a word if it is empty, or if its current word leaves
  // this same cycle (drain-and-refill without a bubble).
  assign avail      = ~valid_q | out_ready;
  assign start_full = rr_next(rr_idx_t'(last_q), N);
  assign start      = start_full[IW-1:0];

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .avail (avail),
    .start (start),
    .found (found),
    .sel   (sel)
  );

  assign in_ready = found;
  assign accept   = in_valid && found;

  always_comb begin
    valid_d = valid_q & ~out_ready;
    data_d  = data_q;
    last_d  = last_q;
    if (accept) begin
      valid_d[sel] = 1'b1;
      data_d[sel]  = in_data;
      last_d       = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      // Parked on the last lane so the first word after reset lands on lane 0.
      last_q  <= IW'(N-1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign last_lane = last_q;

endmodule : rr_dispatcher
